fc_result_writer: RTL and testbench

//  Write-side counterpart of the FC data mover: accepts the 4-lane result vector
//  (post-ReLU outputs of the four fully-connected cores) via valid/ready and

---
 rtl/fc_result_writer.sv | 143 ++++++++++++++
 tb/tb_fc_result_writer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_result_writer.sv
// rtl/fc_result_writer.sv - serialises 4-lane FC result vectors into the result BRAM
// Captures one vector per handshake and writes its lanes to consecutive word addresses.
module fc_result_writer #(
  parameter int CNT_BIT = 31,
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 12
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  input  logic [AWIDTH-1:0]  i_base_addr,
  output logic               o_idle,
  output logic               o_run,
  output logic               o_done,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DWIDTH-1:0]  i_result_0,
  input  logic [DWIDTH-1:0]  i_result_1,
  input  logic [DWIDTH-1:0]  i_result_2,
  input  logic [DWIDTH-1:0]  i_result_3,
  output logic [AWIDTH-1:0]  addr_b2,
  output logic               ce_b2,
  output logic               we_b2,
  output logic [DWIDTH-1:0]  d_b2,
  input  logic [DWIDTH-1:0]  q_b2
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_BIT-1:0] num_q, num_d;
  logic [CNT_BIT-1:0] vec_q, vec_d;
  logic [AWIDTH-1:0]  base_q, base_d;
  logic [1:0]         lane_q, lane_d;
  logic [DWIDTH-1:0]  hold_q [4];
  logic [DWIDTH-1:0]  hold_d [4];

  logic last_vec;
  logic ready;
  logic capture;
  logic writing;
  logic unused_q_b2;

  assign unused_q_b2 = ^q_b2;

  // Only the lane-3 cycle of a non-final vector can overlap the next capture.
  assign last_vec = (vec_q == num_q - CNT_BIT'(1));
  assign ready    = (state_q == S_WAIT) ||
                    ((state_q == S_WRITE) && (lane_q == 2'd3) && !last_vec);
  assign capture  = i_valid && ready;
  assign writing  = (state_q == S_WRITE);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    vec_d   = vec_q;
    base_d  = base_q;
    lane_d  = lane_q;
    hold_d  = hold_q;

    if (capture) begin
      hold_d[0] = i_result_0;
      hold_d[1] = i_result_1;
      hold_d[2] = i_result_2;
      hold_d[3] = i_result_3;
    end

    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          num_d   = i_num_cnt;
          base_d  = i_base_addr;
          vec_d   = '0;
          lane_d  = 2'd0;
          state_d = (i_num_cnt == '0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (capture) begin
          state_d = S_WRITE;
          lane_d  = 2'd0;
        end
      end
      S_WRITE: begin
        lane_d = lane_q + 2'd1;
        if (lane_q == 2'd3) begin
          vec_d = vec_q + CNT_BIT'(1);
          if (last_vec) begin
            state_d = S_DONE;
          end else if (!capture) begin
            state_d = S_WAIT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      vec_q   <= '0;
      base_q  <= '0;
      lane_q  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      vec_q   <= vec_d;
      base_q  <= base_d;
      lane_q  <= lane_d;
      for (int i = 0; i < 4; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign o_idle  = (state_q == S_IDLE);
  assign o_run   = (state_q == S_WAIT) || (state_q == S_WRITE);
  assign o_done  = (state_q == S_DONE);
  assign o_ready = ready;

  // Bus is quiet outside WRITE; address arithmetic wraps at the BRAM depth.
  assign ce_b2   = writing;
  assign we_b2   = writing;
  assign addr_b2 = writing ? (base_q + {vec_q[AWIDTH-3:0], lane_q}) : '0;
  assign d_b2    = writing ? hold_q[lane_q] : '0;

endmodule

// File: tb/tb_fc_result_writer.sv
// tb/tb_fc_result_writer.sv - scoreboard bench for fc_result_writer
module tb_fc_result_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run;
  logic [30:0] i_num_cnt;
  logic [11:0] i_base_addr;
  logic        o_idle, o_run, o_done;
  logic        i_valid, o_ready;
  logic [31:0] i_result_0, i_result_1, i_result_2, i_result_3;
  logic [11:0] addr_b2;
  logic        ce_b2, we_b2;
  logic [31:0] d_b2;
  logic [31:0] q_b2;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  fc_result_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_run       (i_run),
    .i_num_cnt   (i_num_cnt),
    .i_base_addr (i_base_addr),
    .o_idle      (o_idle),
    .o_run       (o_run),
    .o_done      (o_done),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_result_0  (i_result_0),
    .i_result_1  (i_result_1),
    .i_result_2  (i_result_2),
    .i_result_3  (i_result_3),
    .addr_b2     (addr_b2),
    .ce_b2       (ce_b2),
    .we_b2       (we_b2),
    .d_b2        (d_b2),
    .q_b2        (q_b2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic set_vec(input int v);
    i_result_0 = 32'hC0DE0000 + 32'(16 * v + 0);
    i_result_1 = 32'hC0DE0000 + 32'(16 * v + 1);
    i_result_2 = 32'hC0DE0000 + 32'(16 * v + 2);
    i_result_3 = 32'hC0DE0000 + 32'(16 * v + 3);
  endtask

  // Monitor: every BRAM write must match the next expected (addr, data).
  always @(negedge clk) begin
    if (reset_n && ce_b2) begin
      check("we_eq_ce", we_b2, 1);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", addr_b2, d_b2);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", addr_b2, mon_e.addr);
        check("wr_data", d_b2, mon_e.data);
      end
    end
  end

  task automatic run_single(input logic [11:0] base, input logic [31:0] a, b, c, d, input bit disturb);
    if (disturb) begin
      i_valid = 1'b1;
      i_result_0 = 32'hDEAD0000;
      check("idle_ready", o_ready, 0);
      tick;
      i_valid = 1'b0;
      check("idle_after_valid", o_idle, 1);
    end
    i_base_addr = base;
    i_num_cnt = 31'd1;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    check("wait_run", o_run, 1);
    check("wait_ready", o_ready, 1);
    push(base, a);
    push(base + 12'd1, b);
    push(base + 12'd2, c);
    push(base + 12'd3, d);
    i_result_0 = a; i_result_1 = b; i_result_2 = c; i_result_3 = d;
    i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    i_result_0 = '0; i_result_1 = '0; i_result_2 = '0; i_result_3 = '0;
    check("lane0_ce", ce_b2, 1);
    tick;
    if (disturb) begin
      i_run = 1'b1;
      i_num_cnt = 31'd5;
      i_base_addr = 12'h080;
      i_valid = 1'b1;
    end
    tick;
    i_run = 1'b0;
    i_valid = 1'b0;
    tick;
    check("lane3_ready_last", o_ready, 0);
    tick;
    check("done_pulse", o_done, 1);
    check("done_run", o_run, 0);
    tick;
    check("idle_after_done", o_idle, 1);
    check("done_cleared", o_done, 0);
    check("sb_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    i_run = 1'b0;
    i_num_cnt = '0;
    i_base_addr = '0;
    i_valid = 1'b0;
    q_b2 = '0;
    set_vec(0);
    tick;
    tick;
    check("rst_idle", o_idle, 1);
    check("rst_run", o_run, 0);
    check("rst_done", o_done, 0);
    check("rst_ready", o_ready, 0);
    check("rst_addr", addr_b2, 0);
    check("rst_ce", ce_b2, 0);
    check("rst_we", we_b2, 0);
    check("rst_d", d_b2, 0);
    reset_n = 1'b1;
    tick;

    // Single vector from base 0.
    run_single(12'h000, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);

    // Three back-to-back vectors with valid held high.
    i_base_addr = 12'h010;
    i_num_cnt = 31'd3;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    for (int v = 0; v < 3; v++) begin
      for (int l = 0; l < 4; l++) begin
        push(12'h010 + 12'(4 * v + l), 32'hC0DE0000 + 32'(16 * v + l));
      end
    end
    set_vec(0);
    i_valid = 1'b1;
    for (int k = 0; k < 13; k++) begin
      check("s2_ready", o_ready, (k == 0 || k == 4 || k == 8));
      tick;
      if (k == 0 || k == 4 || k == 8) set_vec(k / 4 + 1);
    end
    i_valid = 1'b0;
    check("s2_done", o_done, 1);
    tick;
    check("s2_idle", o_idle, 1);
    check("s2_drained", 64'(exp_q.size()), 0);

    // Zero-length job.
    i_num_cnt = '0;
    i_base_addr = 12'h123;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    check("s3_done", o_done, 1);
    check("s3_ce", ce_b2, 0);
    check("s3_ready", o_ready, 0);
    tick;
    check("s3_idle", o_idle, 1);
    check("s3_done_clr", o_done, 0);

    // Address wrap at the top of the BRAM.
    run_single(12'hFFE, 32'd5, 32'd6, 32'd7, 32'd8, 1'b0);

    // Reset during lane 1 of the first vector.
    i_base_addr = 12'h020;
    i_num_cnt = 31'd2;
    i_run = 1'b1;
    tick;
    i_run = 1'b0;
    push(12'h020, 32'd9);
    i_result_0 = 32'd9; i_result_1 = 32'd10; i_result_2 = 32'd11; i_result_3 = 32'd12;
    i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    tick;
    reset_n = 1'b0;
    #1;
    check("s5_ce", ce_b2, 0);
    check("s5_we", we_b2, 0);
    check("s5_idle", o_idle, 1);
    check("s5_addr", addr_b2, 0);
    tick;
    reset_n = 1'b1;
    tick;
    check("s5_drained", 64'(exp_q.size()), 0);
    run_single(12'h020, 32'd13, 32'd14, 32'd15, 32'd16, 1'b0);

    // Stray valid in IDLE and run re-pulsed mid-write are ignored.
    run_single(12'h000, 32'd1, 32'd2, 32'd3, 32'd4, 1'b1);

    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
